// File: rtl/mem_controller.sv
// Memory-controller stage: loads DMA beats into a local memory at a base address from core_control,
// then serves range-checked registered reads to the processing unit and reports status.
module mem_controller #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic [ADDR_W-1:0] mc_data_address,
  input  logic              mc_we,
  input  logic              ctrl_last_data,
  input  logic [DATA_W-1:0] dma_data_in,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic              mc_rd_req,
  input  logic [ADDR_W-1:0] mc_rd_addr,
  output logic [DATA_W-1:0] mc_rd_data,
  output logic              mc_rd_valid,
  input  logic              procc_done,
  input  logic              mc_err_clr,
  output logic              mc_cont_procc,
  output logic              mc_data_done,
  output logic              mc_err,
  output logic [ADDR_W:0]   mc_word_count
);

  typedef enum logic [2:0] {StIdle, StLoad, StProcc, StDone, StErr} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_base, w_base_next;
  logic [ADDR_W-1:0] r_wptr, w_wptr_next;
  logic [ADDR_W:0]   r_count, w_count_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_beat;
  logic              w_rd_in_range;
  logic              w_rd_hit;

  // Ready is decoded from LOAD, so valid alone qualifies a beat there.
  assign w_beat = (r_state == StLoad) && dma_valid;

  // Widened by one bit so base+count cannot wrap at the top of memory.
  assign w_rd_in_range = ({1'b0, mc_rd_addr} >= {1'b0, r_base}) &&
                         ({1'b0, mc_rd_addr} < ({1'b0, r_base} + r_count));
  assign w_rd_hit      = (r_state == StProcc) && mc_rd_req && w_rd_in_range;

  always_comb begin
    w_state_next = r_state;
    w_base_next  = r_base;
    w_wptr_next  = r_wptr;
    w_count_next = r_count;
    unique case (r_state)
      StIdle, StDone: begin
        if (mc_we) begin
          w_state_next = StLoad;
          w_base_next  = mc_data_address;
          w_wptr_next  = mc_data_address;
          w_count_next = '0;
        end
      end
      StLoad: begin
        if (w_beat) begin
          w_wptr_next  = r_wptr + ADDR_W'(1);
          w_count_next = r_count + (ADDR_W + 1)'(1);
          if (ctrl_last_data) begin
            w_state_next = StProcc;
          end else if (r_wptr == LastAddr) begin
            w_state_next = StErr;
          end
        end
      end
      StProcc: begin
        // An out-of-range read wins over a simultaneous procc_done.
        if (mc_rd_req && !w_rd_in_range) begin
          w_state_next = StErr;
        end else if (procc_done) begin
          w_state_next = StDone;
        end
      end
      StErr: begin
        if (mc_err_clr) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_base     <= w_base_next;
      r_wptr     <= w_wptr_next;
      r_count    <= w_count_next;
      r_rd_valid <= w_rd_hit;
      if (w_rd_hit) begin
        r_rd_data <= r_mem[mc_rd_addr];
      end
    end
  end

  // Memory is never reset; a beat coinciding with reset is dropped.
  always_ff @(posedge mc_clk) begin
    if (w_beat && !mc_reset) begin
      r_mem[r_wptr] <= dma_data_in;
    end
  end

  assign dma_ready     = (r_state == StLoad);
  assign mc_cont_procc = (r_state == StProcc);
  assign mc_data_done  = (r_state == StDone);
  assign mc_err        = (r_state == StErr);
  assign mc_rd_data    = r_rd_data;
  assign mc_rd_valid   = r_rd_valid;
  assign mc_word_count = r_count;

endmodule

// File: tb/tb_mem_controller.sv
// Directed self-checking bench for mem_controller: load, stalls, overflow, range errors,
// done/restart and reset during a load.
module tb_mem_controller;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic              mc_clk = 1'b0;
  logic              mc_reset;
  logic [ADDR_W-1:0] mc_data_address;
  logic              mc_we;
  logic              ctrl_last_data;
  logic [DATA_W-1:0] dma_data_in;
  logic              dma_valid;
  logic              dma_ready;
  logic              mc_rd_req;
  logic [ADDR_W-1:0] mc_rd_addr;
  logic [DATA_W-1:0] mc_rd_data;
  logic              mc_rd_valid;
  logic              procc_done;
  logic              mc_err_clr;
  logic              mc_cont_procc;
  logic              mc_data_done;
  logic              mc_err;
  logic [ADDR_W:0]   mc_word_count;

  int checks = 0;
  int errors = 0;

  mem_controller #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .mc_clk         (mc_clk),
    .mc_reset       (mc_reset),
    .mc_data_address(mc_data_address),
    .mc_we          (mc_we),
    .ctrl_last_data (ctrl_last_data),
    .dma_data_in    (dma_data_in),
    .dma_valid      (dma_valid),
    .dma_ready      (dma_ready),
    .mc_rd_req      (mc_rd_req),
    .mc_rd_addr     (mc_rd_addr),
    .mc_rd_data     (mc_rd_data),
    .mc_rd_valid    (mc_rd_valid),
    .procc_done     (procc_done),
    .mc_err_clr     (mc_err_clr),
    .mc_cont_procc  (mc_cont_procc),
    .mc_data_done   (mc_data_done),
    .mc_err         (mc_err),
    .mc_word_count  (mc_word_count)
  );

  always #5 mc_clk = ~mc_clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] data, input logic valid, input logic last);
    dma_data_in    = data;
    dma_valid      = valid;
    ctrl_last_data = last;
    tick();
    dma_valid      = 1'b0;
    ctrl_last_data = 1'b0;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] addr);
    mc_data_address = addr;
    mc_we           = 1'b1;
    tick();
    mc_we           = 1'b0;
  endtask

  task automatic test_reset();
    mc_reset = 1'b1;
    mc_we = 1'b0; mc_data_address = '0; ctrl_last_data = 1'b0; dma_data_in = '0;
    dma_valid = 1'b0; mc_rd_req = 1'b0; mc_rd_addr = '0; procc_done = 1'b0; mc_err_clr = 1'b0;
    tick();
    tick();
    checks++; if (dma_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", dma_ready); end
    checks++; if (mc_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", mc_rd_data); end
    checks++; if (mc_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", mc_rd_valid); end
    checks++; if ({mc_cont_procc, mc_data_done, mc_err} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {mc_cont_procc, mc_data_done, mc_err}); end
    checks++; if (mc_word_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", mc_word_count); end
    mc_reset = 1'b0;
    // Beats in IDLE must be ignored.
    beat(32'hDEAD, 1'b1, 1'b1);
    checks++; if (dma_ready !== 1'b0 || mc_word_count !== 7'd0) begin errors++; $display("FAIL idle_ignore got ready=%b count=%0d exp 0/0", dma_ready, mc_word_count); end
  endtask

  task automatic test_basic();
    start_load(6'h10);
    checks++; if (dma_ready !== 1'b1 || mc_word_count !== 7'd0) begin errors++; $display("FAIL basic_load_entry got ready=%b count=%0d exp 1/0", dma_ready, mc_word_count); end
    for (int i = 0; i < 3; i++) beat(32'hA0 + i, 1'b1, 1'b0);
    checks++; if (mc_word_count !== 7'd3 || mc_cont_procc !== 1'b0) begin errors++; $display("FAIL basic_mid got count=%0d procc=%b exp 3/0", mc_word_count, mc_cont_procc); end
    beat(32'hA3, 1'b1, 1'b1);
    checks++; if (mc_word_count !== 7'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", mc_word_count); end
    checks++; if (mc_cont_procc !== 1'b1 || dma_ready !== 1'b0) begin errors++; $display("FAIL basic_procc got procc=%b ready=%b exp 1/0", mc_cont_procc, dma_ready); end
    mc_rd_req = 1'b1; mc_rd_addr = 6'h12;
    tick();
    mc_rd_req = 1'b0;
    checks++; if (mc_rd_valid !== 1'b1 || mc_rd_data !== 32'hA2) begin errors++; $display("FAIL basic_read got v=%b d=%h exp 1/a2", mc_rd_valid, mc_rd_data); end
    tick();
    checks++; if (mc_rd_valid !== 1'b0) begin errors++; $display("FAIL basic_read_pulse got %b exp 0", mc_rd_valid); end
  endtask

  task automatic test_back_to_back();
    mc_rd_req = 1'b1; mc_rd_addr = 6'h10;
    tick();
    checks++; if (mc_rd_valid !== 1'b1 || mc_rd_data !== 32'hA0) begin errors++; $display("FAIL b2b_first got v=%b d=%h exp 1/a0", mc_rd_valid, mc_rd_data); end
    mc_rd_addr = 6'h13;
    tick();
    mc_rd_req = 1'b0;
    checks++; if (mc_rd_valid !== 1'b1 || mc_rd_data !== 32'hA3) begin errors++; $display("FAIL b2b_second got v=%b d=%h exp 1/a3", mc_rd_valid, mc_rd_data); end
    procc_done = 1'b1;
    tick();
    procc_done = 1'b0;
    checks++; if (mc_data_done !== 1'b1 || mc_cont_procc !== 1'b0 || mc_word_count !== 7'd4) begin errors++; $display("FAIL b2b_done got done=%b procc=%b count=%0d exp 1/0/4", mc_data_done, mc_cont_procc, mc_word_count); end
  endtask

  task automatic test_stall();
    start_load(6'h00);
    beat(32'hB0, 1'b1, 1'b0);
    beat(32'hB1, 1'b0, 1'b1);
    beat(32'hB2, 1'b0, 1'b0);
    beat(32'hB3, 1'b1, 1'b0);
    checks++; if (mc_word_count !== 7'd2 || dma_ready !== 1'b1) begin errors++; $display("FAIL stall_mid got count=%0d ready=%b exp 2/1", mc_word_count, dma_ready); end
    beat(32'hB4, 1'b1, 1'b1);
    checks++; if (mc_word_count !== 7'd3 || mc_cont_procc !== 1'b1) begin errors++; $display("FAIL stall_count got count=%0d procc=%b exp 3/1", mc_word_count, mc_cont_procc); end
    mc_rd_req = 1'b1; mc_rd_addr = 6'h01;
    tick();
    checks++; if (mc_rd_valid !== 1'b1 || mc_rd_data !== 32'hB3) begin errors++; $display("FAIL stall_rd1 got v=%b d=%h exp 1/b3", mc_rd_valid, mc_rd_data); end
    mc_rd_addr = 6'h02;
    tick();
    mc_rd_req = 1'b0;
    checks++; if (mc_rd_valid !== 1'b1 || mc_rd_data !== 32'hB4) begin errors++; $display("FAIL stall_rd2 got v=%b d=%h exp 1/b4", mc_rd_valid, mc_rd_data); end
    procc_done = 1'b1;
    tick();
    procc_done = 1'b0;
  endtask

  task automatic test_overflow();
    start_load(6'h3E);
    beat(32'hC0, 1'b1, 1'b0);
    checks++; if (dma_ready !== 1'b1 || mc_err !== 1'b0) begin errors++; $display("FAIL ovf_first got ready=%b err=%b exp 1/0", dma_ready, mc_err); end
    beat(32'hC1, 1'b1, 1'b0);
    checks++; if (mc_err !== 1'b1 || dma_ready !== 1'b0 || mc_word_count !== 7'd2) begin errors++; $display("FAIL ovf_err got err=%b ready=%b count=%0d exp 1/0/2", mc_err, dma_ready, mc_word_count); end
    beat(32'hC2, 1'b1, 1'b0);
    checks++; if (dut.r_mem[62] !== 32'hC0 || dut.r_mem[63] !== 32'hC1) begin errors++; $display("FAIL ovf_mem_top got %h %h exp c0 c1", dut.r_mem[62], dut.r_mem[63]); end
    checks++; if (dut.r_mem[0] !== 32'hB0) begin errors++; $display("FAIL ovf_no_wrap got %h exp b0", dut.r_mem[0]); end
    mc_rd_req = 1'b1; mc_rd_addr = 6'h3E;
    tick();
    mc_rd_req = 1'b0;
    checks++; if (mc_rd_valid !== 1'b0 || mc_err !== 1'b1) begin errors++; $display("FAIL err_read_ignored got v=%b err=%b exp 0/1", mc_rd_valid, mc_err); end
    mc_err_clr = 1'b1;
    tick();
    mc_err_clr = 1'b0;
    checks++; if (mc_err !== 1'b0 || dma_ready !== 1'b0 || mc_data_done !== 1'b0 || mc_cont_procc !== 1'b0) begin errors++; $display("FAIL ovf_clr got err=%b ready=%b done=%b procc=%b exp 0/0/0/0", mc_err, dma_ready, mc_data_done, mc_cont_procc); end
  endtask

  task automatic test_out_of_range();
    start_load(6'h05);
    beat(32'hD0, 1'b1, 1'b0);
    beat(32'hD1, 1'b1, 1'b1);
    checks++; if (mc_cont_procc !== 1'b1 || mc_word_count !== 7'd2) begin errors++; $display("FAIL oor_load got procc=%b count=%0d exp 1/2", mc_cont_procc, mc_word_count); end
    mc_rd_req = 1'b1; mc_rd_addr = 6'h07;
    tick();
    mc_rd_req = 1'b0;
    checks++; if (mc_rd_valid !== 1'b0 || mc_err !== 1'b1 || mc_cont_procc !== 1'b0) begin errors++; $display("FAIL oor_err got v=%b err=%b procc=%b exp 0/1/0", mc_rd_valid, mc_err, mc_cont_procc); end
    mc_err_clr = 1'b1;
    tick();
    mc_err_clr = 1'b0;
    checks++; if (mc_err !== 1'b0) begin errors++; $display("FAIL oor_clr got %b exp 0", mc_err); end
  endtask

  task automatic test_done_restart();
    start_load(6'h05);
    beat(32'hE0, 1'b1, 1'b0);
    beat(32'hE1, 1'b1, 1'b1);
    mc_rd_req = 1'b1; mc_rd_addr = 6'h05; procc_done = 1'b1;
    tick();
    mc_rd_req = 1'b0; procc_done = 1'b0;
    checks++; if (mc_rd_valid !== 1'b1 || mc_rd_data !== 32'hE0) begin errors++; $display("FAIL done_read got v=%b d=%h exp 1/e0", mc_rd_valid, mc_rd_data); end
    checks++; if (mc_data_done !== 1'b1 || mc_cont_procc !== 1'b0) begin errors++; $display("FAIL done_state got done=%b procc=%b exp 1/0", mc_data_done, mc_cont_procc); end
    mc_err_clr = 1'b1;
    tick();
    mc_err_clr = 1'b0;
    checks++; if (mc_data_done !== 1'b1 || mc_rd_valid !== 1'b0 || mc_word_count !== 7'd2) begin errors++; $display("FAIL done_hold got done=%b v=%b count=%0d exp 1/0/2", mc_data_done, mc_rd_valid, mc_word_count); end
    start_load(6'h20);
    checks++; if (mc_word_count !== 7'd0 || mc_data_done !== 1'b0 || dma_ready !== 1'b1) begin errors++; $display("FAIL restart got count=%0d done=%b ready=%b exp 0/0/1", mc_word_count, mc_data_done, dma_ready); end
  endtask

  task automatic test_reset_mid_load();
    // Preload 0x20..0x23 so the aborted load leaves known contents behind.
    for (int i = 0; i < 4; i++) beat(32'h11 + i, 1'b1, i == 3);
    procc_done = 1'b1;
    tick();
    procc_done = 1'b0;
    start_load(6'h20);
    beat(32'hF0, 1'b1, 1'b0);
    beat(32'hF1, 1'b1, 1'b0);
    mc_reset = 1'b1; dma_data_in = 32'hF2; dma_valid = 1'b1; mc_rd_req = 1'b1; mc_rd_addr = 6'h20;
    tick();
    mc_reset = 1'b0; mc_rd_req = 1'b0;
    checks++; if ({dma_ready, mc_rd_valid, mc_cont_procc, mc_data_done, mc_err} !== 5'b0 || mc_word_count !== 7'd0 || mc_rd_data !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs got flags=%b count=%0d d=%h exp 0", {dma_ready, mc_rd_valid, mc_cont_procc, mc_data_done, mc_err}, mc_word_count, mc_rd_data); end
    dma_data_in = 32'hF3;
    tick();
    tick();
    dma_valid = 1'b0;
    checks++; if (dut.r_mem[32] !== 32'hF0 || dut.r_mem[33] !== 32'hF1) begin errors++; $display("FAIL rst_mid_written got %h %h exp f0 f1", dut.r_mem[32], dut.r_mem[33]); end
    checks++; if (dut.r_mem[34] !== 32'h13 || dut.r_mem[35] !== 32'h14) begin errors++; $display("FAIL rst_mid_no_write got %h %h exp 13 14", dut.r_mem[34], dut.r_mem[35]); end
    checks++; if (dma_ready !== 1'b0 || mc_word_count !== 7'd0) begin errors++; $display("FAIL rst_mid_idle got ready=%b count=%0d exp 0/0", dma_ready, mc_word_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_out_of_range();
    test_done_restart();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Memory-controller stage directly downstream of core_control.
- Accepts the base address and write-enable that core_control drives (mc_data_address_out and mc_we).
- Streams incoming DMA data words into a local single-port-write / registered-read data memory.
- Serves reads from the processing unit and reports status back to core_control on mc_cont_procc, mc_data_done and mc_err.

Parameters:
DATA_W, 32, data word width
ADDR_W, 6, address width; must match core_control's 6-bit data address
DEPTH, 64, memory depth; must equal 2**ADDR_W

Ports:
mc_clk  in  1  clock; all logic on rising edge
mc_reset  in  1  synchronous, active-high reset
mc_data_address  in  ADDR_W  base address from core_control; sampled when mc_we=1 in IDLE/DONE
mc_we  in  1  start-load request from core_control
ctrl_last_data  in  1  marks the DMA beat accepted in the same cycle as the final beat
dma_data_in  in  DATA_W  incoming data word
dma_valid  in  1  dma_data_in valid
dma_ready  out  1  controller can accept a beat
mc_rd_req  in  1  processing-unit read strobe
mc_rd_addr  in  ADDR_W  read address
mc_rd_data  out  DATA_W  read data
mc_rd_valid  out  1  mc_rd_data valid, one-cycle pulse
procc_done  in  1  processing unit finished
mc_err_clr  in  1  clears the sticky error
mc_cont_procc  out  1  data loaded; processing may proceed
mc_data_done  out  1  transaction complete
mc_err  out  1  sticky error flag
mc_word_count  out  ADDR_W+1  number of words loaded in the current transaction

Behaviour:
- Reset (mc_reset=1 at a clock edge):
  - state=IDLE.
  - All outputs 0, including mc_rd_data, mc_word_count and dma_ready.
  - Write pointer and base register are 0.
  - Memory contents are not reset.
  - Reset mid-transaction aborts immediately; no further writes occur.
- States: IDLE, LOAD, PROCC, DONE, ERR. State is registered; all outputs are registered or decoded from state.
- IDLE:
  - dma_ready=0; dma_valid is ignored.
  - mc_we=1 → LOAD. Latch base=mc_data_address, wptr=mc_data_address, count=0.
- LOAD:
  - dma_ready=1.
  - A beat is accepted when dma_valid&dma_ready: mem[wptr]<=dma_data_in, wptr<=wptr+1, count<=count+1.
  - Accepted beat with ctrl_last_data=1 → PROCC on the next cycle. That beat is written.
  - ctrl_last_data without dma_valid is ignored.
  - mc_we in LOAD is ignored.
  - Overflow: if a beat is accepted at wptr=DEPTH-1 and ctrl_last_data=0, the beat is written and the next state is ERR. No wrap-around.
- PROCC:
  - mc_cont_procc=1 (level); dma_ready=0.
  - Read: on mc_rd_req=1, mc_rd_data and mc_rd_valid are driven in the following cycle (latency 1).
  - Valid reads cover base ≤ mc_rd_addr ≤ base+count-1.
  - Out-of-range read → ERR. mc_rd_valid stays 0 for that request.
  - Back-to-back reads are allowed at one per cycle.
  - procc_done=1 → DONE.
  - procc_done and mc_rd_req in the same cycle: the read completes normally (valid pulse next cycle), then the state is DONE.
- DONE:
  - mc_data_done=1 (level); mc_cont_procc=0; mc_word_count holds.
  - mc_we=1 → LOAD with a new base (same actions as from IDLE).
  - Otherwise remain in DONE.
- ERR:
  - mc_err=1; all other status outputs 0; dma_ready=0; reads are ignored.
  - mc_err_clr=1 → IDLE, with mc_err cleared the next cycle.
  - mc_err_clr outside ERR has no effect.
- mc_word_count updates on every accepted beat. It is cleared on entry to LOAD.
- Max value is DEPTH (base=0, full load). This is why the output is ADDR_W+1 bits wide.

Test Plan:
- Basic load/read:
  - Stimulus: reset; mc_we=1, addr=0x10; then 4 beats 0xA0..0xA3, last beat with ctrl_last_data=1.
  - Required: mc_word_count=4; mc_cont_procc=1 the cycle after the last beat.
  - Stimulus: read 0x12.
  - Required: mc_rd_data=0xA2 with mc_rd_valid one cycle later.
- DMA stalls:
  - Stimulus: dma_valid toggled 1,0,0,1,1 in LOAD.
  - Required: only valid cycles write; addresses stay contiguous; count=3.
- Overflow:
  - Stimulus: base=0x3E; 3 beats with no last.
  - Required: mem[0x3E], mem[0x3F] written; mc_err=1; dma_ready=0; mem[0x00] unchanged.
  - Stimulus: mc_err_clr pulse.
  - Required: IDLE; mc_err=0.
- Out-of-range read:
  - Stimulus: load 2 words at 0x05; read 0x07.
  - Required: no mc_rd_valid; mc_err=1.
- Done/restart:
  - Stimulus: procc_done asserted with a simultaneous read of 0x05.
  - Required: mc_rd_valid pulse, then mc_data_done=1.
  - Stimulus: mc_we with addr=0x20.
  - Required: LOAD; mc_word_count=0; mc_data_done=0.
- Reset mid-LOAD:
  - Stimulus: assert mc_reset after 2 of 4 beats.
  - Required: next cycle all outputs 0; further dma_valid beats are not written.
